ad_sync_ctrl: RTL
=================

AD_SYNC_CTRL -- requirements
Module: ad_sync_ctrl

Interface
REQ-001 Parameter LW_WIDTH, default 13: width of the line-width counter and of iv_line_width.
REQ-002 Parameter PIPE_LAT, default 2: latency in clk cycles from the pixel source to the latch sync-replace stage; o_pix_req leads the active window by this amount.
REQ-003 clk  in  1  pixel clock; all logic is on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 i_line_start  in  1  one-cycle pulse requesting one line.
REQ-006 iv_line_width  in  LW_WIDTH  active pixels per line; sampled on an accepted start.
REQ-007 iv_sol_code / iv_eol_code  in  16  code words that terminate the SOL and EOL headers.
REQ-008 i_frame_last  in  1  marks the current line as the last in the frame; sampled on an accepted start (used only under AD_SYNC_FRAME_EN).
REQ-009 iv_sof_code / iv_eof_code  in  16  frame codes (used only under AD_SYNC_FRAME_EN).
REQ-010 o_sync_word_sel  out  1  drives the latch sync-replace select.
REQ-011 ov_sync_word  out  16  drives the latch sync word.
REQ-012 o_pix_req  out  1  requests one pixel per cycle from the upstream source.
REQ-013 o_busy  out  1  high while a line is in progress.
REQ-014 o_start_err  out  1  one-cycle pulse when a start is dropped.

Function
REQ-015 States: IDLE, SOL, ACT, EOL; SOL and EOL each last exactly 4 cycles, indexed by a 2-bit word counter.
REQ-016 A start is accepted only in IDLE; at the accepting cycle (call it T) the block latches the width, the codes and i_frame_last.
REQ-017 Header word sequence: 16'hFFFF, 16'h0000, 16'h0000, then the code word.
REQ-018 SOL timing: o_sync_word_sel=1 with the SOL sequence on T+1..T+4.
REQ-019 ACT timing, with W = latched width: o_sync_word_sel=0 on T+5..T+4+W; ov_sync_word holds 16'h0000 during ACT.
REQ-020 EOL timing: o_sync_word_sel=1 with the EOL sequence on T+5+W..T+8+W; the block then returns to IDLE.
REQ-021 o_pix_req is high for exactly W cycles, T+5-PIPE_LAT..T+4+W-PIPE_LAT, so pixels reach the latch aligned to ACT.
REQ-022 W=0: the block goes SOL to EOL directly, EOL occupies T+5..T+8, and o_pix_req never asserts.
REQ-023 o_busy is high on T+1..T+8+W and low in IDLE.
REQ-024 A start received while o_busy=1 is ignored and pulses o_start_err one cycle later; the line in progress is unaffected.
REQ-025 Any change to iv_line_width or the codes after T has no effect on the current line.
REQ-026 All outputs are registered; there are no combinational input-to-output paths.
REQ-027 The ACT counter is LW_WIDTH bits wide and counts down from W; it shall not wrap at W = 2^LW_WIDTH-1.

Reset
REQ-028 When reset=1: state = IDLE, o_sync_word_sel=0, ov_sync_word=16'h0000, o_pix_req=0, o_busy=0, o_start_err=0, and all counters are 0.
REQ-029 Reset asserted mid-line aborts the line immediately; the first start after reset releases is accepted normally.
REQ-030 A start coincident with reset is ignored.

Configuration
REQ-031 Macro AD_SYNC_FRAME_EN.
REQ-032 With AD_SYNC_FRAME_EN defined:
- the first accepted line after reset, and the first line after a line flagged i_frame_last, uses iv_sof_code in place of iv_sol_code;
- a line whose start sampled i_frame_last=1 uses iv_eof_code in place of iv_eol_code.
REQ-033 Without AD_SYNC_FRAME_EN, i_frame_last, iv_sof_code and iv_eof_code are unused, and no frame-tracking flop exists.

Structure
REQ-034 The preamble constants (16'hFFFF, 16'h0000), the header length (4) and the state encodings live in the shared AD-model definitions include, ad_sync_def.
REQ-035 The block is a single module with no sub-module.

Verification
REQ-036 W=8, SOL=16'hABC0, EOL=16'hABC1, start at T:
- sel=1 on T+1..T+4 with words FFFF,0000,0000,ABC0;
- sel=0 on T+5..T+12;
- EOL sequence ending in ABC1 on T+13..T+16;
- o_pix_req high on T+3..T+10.
REQ-037 W=0: EOL on T+5..T+8, o_pix_req stays low, o_busy falls at T+9.
REQ-038 Second start at T+6 with W=8: o_start_err pulses at T+7 and the first line completes unchanged; a start at T+17 is accepted.
REQ-039 Reset at T+7 of a W=8 line: all outputs are at reset values at T+8; a start at T+10 yields a clean SOL on T+11..T+14.
REQ-040 W=8191: the ACT window lasts exactly 8191 cycles with no counter wrap.
REQ-041 Under AD_SYNC_FRAME_EN, with three lines where the third has i_frame_last=1:
- line 1 ends its SOL with the SOF code;
- line 3 ends its EOL with the EOF code;
- line 4 ends its SOL with the SOF code.

Source files
------------

// File: rtl/ad_sync_ctrl_pkg.sv
// ad_sync_ctrl_pkg: shared AD-model sync definitions (preamble words,
// header length, FSM state encodings, header word helper).
package ad_sync_ctrl_pkg;

  localparam int unsigned HDR_LEN        = 4;
  localparam logic [1:0]  HDR_LAST       = 2'(HDR_LEN - 1);
  localparam logic [15:0] SYNC_PRE_WORD  = 16'hFFFF;
  localparam logic [15:0] SYNC_ZERO_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOL  = 2'd1,
    ST_ACT  = 2'd2,
    ST_EOL  = 2'd3
  } state_t;

  // Header word at position idx: preamble, two zero words, then the code.
  function automatic logic [15:0] hdr_word(input logic [1:0]  idx,
                                           input logic [15:0] code);
    if (idx == 2'd0) begin
      return SYNC_PRE_WORD;
    end else if (idx == HDR_LAST) begin
      return code;
    end else begin
      return SYNC_ZERO_WORD;
    end
  endfunction

endpackage

// File: rtl/ad_sync_ctrl.sv
// ad_sync_ctrl: per-line sync header sequencer for the AD latch stage.
// Emits SOL header, ACT window (pixel request led by PIPE_LAT), EOL header.
// Optional macro AD_SYNC_FRAME_EN swaps in SOF/EOF codes at frame edges.
// PIPE_LAT is meaningful in the range 0..4 (at most one header length).
module ad_sync_ctrl
  import ad_sync_ctrl_pkg::*;
#(
  parameter int LW_WIDTH = 13,
  parameter int PIPE_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_line_start,
  input  logic [LW_WIDTH-1:0] iv_line_width,
  input  logic [15:0]         iv_sol_code,
  input  logic [15:0]         iv_eol_code,
  input  logic                i_frame_last,
  input  logic [15:0]         iv_sof_code,
  input  logic [15:0]         iv_eof_code,
  output logic                o_sync_word_sel,
  output logic [15:0]         ov_sync_word,
  output logic                o_pix_req,
  output logic                o_busy,
  output logic                o_start_err
);

  localparam logic [LW_WIDTH-1:0] CNT_ONE = {{(LW_WIDTH-1){1'b0}}, 1'b1};
  // When the lead equals the whole SOL header the request starts on accept.
  localparam bit         PIX_AT_ACCEPT = (PIPE_LAT >= 4);
  localparam logic [1:0] PIX_WCNT      = PIX_AT_ACCEPT ? 2'd0 : 2'(3 - PIPE_LAT);

  state_t                state_q;
  logic [1:0]            wcnt_q;
  logic [LW_WIDTH-1:0]   act_cnt_q;
  logic [LW_WIDTH-1:0]   pcnt_q;
  logic [LW_WIDTH-1:0]   wid_q;
  logic [15:0]           sol_code_q;
  logic [15:0]           eol_code_q;
  logic                  sel_q;
  logic [15:0]           word_q;
  logic                  pix_q;
  logic                  busy_q;
  logic                  err_q;

  logic [15:0]           sol_sel_d;
  logic [15:0]           eol_sel_d;
  logic                  pix_go_d;
  logic [LW_WIDTH-1:0]   pix_len_d;

`ifdef AD_SYNC_FRAME_EN
  logic                  sof_pend_q;

  // Pick frame codes for the line being accepted.
  always_comb begin
    sol_sel_d = sof_pend_q   ? iv_sof_code : iv_sol_code;
    eol_sel_d = i_frame_last ? iv_eof_code : iv_eol_code;
  end
`else
  logic unused_frame_inputs;
  assign unused_frame_inputs = ^{i_frame_last, iv_sof_code, iv_eof_code};

  // Without frame tracking the line codes pass straight through.
  always_comb begin
    sol_sel_d = iv_sol_code;
    eol_sel_d = iv_eol_code;
  end
`endif

  // Decide when the pixel request window opens and how long it lasts.
  always_comb begin
    pix_go_d  = 1'b0;
    pix_len_d = wid_q;
    if (PIX_AT_ACCEPT) begin
      pix_go_d  = (state_q == ST_IDLE) && i_line_start && (iv_line_width != '0);
      pix_len_d = iv_line_width;
    end else begin
      pix_go_d  = (state_q == ST_SOL) && (wcnt_q == PIX_WCNT) && (wid_q != '0);
    end
  end

  // Line sequencer: all outputs are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 2'd0;
      act_cnt_q  <= '0;
      pcnt_q     <= '0;
      sel_q      <= 1'b0;
      word_q     <= SYNC_ZERO_WORD;
      pix_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef AD_SYNC_FRAME_EN
      sof_pend_q <= 1'b1;
`endif
    end else begin
      // A start can only land while idle; otherwise it is flagged.
      err_q <= i_line_start && busy_q;

      case (state_q)
        ST_IDLE: begin
          if (i_line_start) begin
            wid_q      <= iv_line_width;
            sol_code_q <= sol_sel_d;
            eol_code_q <= eol_sel_d;
`ifdef AD_SYNC_FRAME_EN
            sof_pend_q <= i_frame_last;
`endif
            state_q    <= ST_SOL;
            wcnt_q     <= 2'd0;
            sel_q      <= 1'b1;
            word_q     <= SYNC_PRE_WORD;
            busy_q     <= 1'b1;
          end
        end
        ST_SOL: begin
          if (wcnt_q == HDR_LAST) begin
            wcnt_q <= 2'd0;
            if (wid_q == '0) begin
              state_q <= ST_EOL;
              word_q  <= hdr_word(2'd0, eol_code_q);
            end else begin
              state_q   <= ST_ACT;
              sel_q     <= 1'b0;
              word_q    <= SYNC_ZERO_WORD;
              act_cnt_q <= wid_q;
            end
          end else begin
            wcnt_q <= wcnt_q + 2'd1;
            word_q <= hdr_word(wcnt_q + 2'd1, sol_code_q);
          end
        end
        ST_ACT: begin
          if (act_cnt_q == CNT_ONE) begin
            state_q   <= ST_EOL;
            act_cnt_q <= '0;
            wcnt_q    <= 2'd0;
            sel_q     <= 1'b1;
            word_q    <= hdr_word(2'd0, eol_code_q);
          end else begin
            act_cnt_q <= act_cnt_q - CNT_ONE;
          end
        end
        ST_EOL: begin
          if (wcnt_q == HDR_LAST) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 2'd0;
            sel_q   <= 1'b0;
            word_q  <= SYNC_ZERO_WORD;
            busy_q  <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + 2'd1;
            word_q <= hdr_word(wcnt_q + 2'd1, eol_code_q);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Pixel request runs W cycles, PIPE_LAT ahead of the ACT window.
      if (pix_q) begin
        if (pcnt_q == CNT_ONE) begin
          pix_q  <= 1'b0;
          pcnt_q <= '0;
        end else begin
          pcnt_q <= pcnt_q - CNT_ONE;
        end
      end else if (pix_go_d) begin
        pix_q  <= 1'b1;
        pcnt_q <= pix_len_d;
      end
    end
  end

  assign o_sync_word_sel = sel_q;
  assign ov_sync_word    = word_q;
  assign o_pix_req       = pix_q;
  assign o_busy          = busy_q;
  assign o_start_err     = err_q;

endmodule
